fetch_ctrl: RTL
===============

# fetch_ctrl

Instruction-fetch sequencer that sits directly upstream of the PC register. It accepts a fetch request from the main control unit, reads the instruction at the current PC through a request/acknowledge memory port, and latches it into the instruction register. It then drives `pcwr`/`pc_src` so the PC register advances to PC+1, or loads the interrupt vector 0x0280 when an enabled interrupt is pending. It also times out stalled memory reads.

## Interface
- `TIMEOUT`, default 15: maximum FETCH cycles without `mem_ack` before abort (1..255).
- `clock` in 1: system clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; one clock, reset is asynchronous and active-high.
- `start` in 1: fetch request from control unit; sampled in IDLE only.
- `pc` in 16: current PC register value.
- `irq` in 1: interrupt request, level-sensitive.
- `irq_en` in 1: interrupt enable.
- `mem_ack` in 1: memory read data valid.
- `mem_data` in 16: memory read data.
- `mem_rd` out 1: memory read request.
- `mem_addr` out 16: memory read address.
- `ir` out 16: instruction register.
- `ir_valid` out 1: one-cycle pulse, new `ir` available.
- `pcwr` out 1: PC write enable to PC register.
- `pc_src` out 2: PC source select (01 = ALU result, 10 = vector 0x0280; 00 otherwise).
- `alu_inc` out 1: requests the datapath ALU compute `pc`+1 on its combinational output.
- `irq_ack` out 1: one-cycle interrupt acknowledge.
- `bus_err` out 1: one-cycle fetch-timeout pulse.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, VECTOR, FETCH, INC.
- Reset value: IDLE, and every output is 0 (`ir` = 0x0000, `mem_addr` = 0x0000, `pc_src` = 00). The wait counter is cleared.
- IDLE
  - If `start` and `irq` and `irq_en` are all high, go to VECTOR.
  - Else if `start` is high, go to FETCH.
  - Else stay in IDLE.
- VECTOR (1 cycle): `pcwr`=1, `pc_src`=10, `irq_ack`=1; then go to FETCH. The PC register loads 0x0280 on the falling edge within this cycle.
- FETCH
  - `mem_rd`=1 and `mem_addr`=`pc` (combinational from `pc`).
  - The wait counter increments each FETCH cycle.
  - On a rising edge with `mem_ack`=1: `ir` ← `mem_data`, go to INC.
  - Else, if the counter has reached `TIMEOUT`: pulse `bus_err` in the next cycle, go to IDLE. `ir` and the PC are unchanged.
  - If `mem_ack` and timeout occur on the same edge, `mem_ack` wins.
- INC (1 cycle): `pcwr`=1, `pc_src`=01, `alu_inc`=1, `ir_valid`=1; then go to IDLE and clear the counter.
- `pcwr` is never high outside VECTOR and INC.
- `start` is ignored while `busy` is high. `irq` is ignored unless `start` is seen in IDLE.
- `mem_data` is captured only in FETCH with `mem_ack`=1. A `mem_ack` seen in any other state is ignored.
- Reset mid-operation: all state and outputs clear immediately, without waiting for a clock edge. `mem_rd` falls at once and no `pcwr` is issued.

## Timing
- Handshake: `start` high at rising edge k, with no interrupt:
  - cycle k+1: FETCH.
  - if `mem_ack` is high at edge k+2: cycle k+2 is INC and `ir` is valid.
  - cycle k+3: IDLE, `busy`=0.
  - Minimum fetch latency is 2 cycles start-to-`ir_valid`. Each memory wait cycle adds 1.
- With an interrupt, VECTOR adds 1 cycle, so `ir_valid` appears at k+3 at the earliest. The fetched address is 0x0280.
- PC-register interaction:
  - The PC register samples `pcwr`/`pc_src` on the falling edge.
  - This block drives them from rising-edge state, so they are stable for the whole high phase.
  - In INC, `pc` shows PC+1 after mid-cycle; `ir` is already latched and unaffected.
- Timeout:
  - With `mem_ack` held low, FETCH lasts exactly `TIMEOUT` cycles.
  - `bus_err` pulses in the first IDLE cycle after FETCH.
- Back-to-back fetches: if `start` is held high, IDLE lasts exactly 1 cycle between fetches.
- `mem_addr` is 0x0000 whenever `mem_rd`=0.

## Test plan
- Reset, then `pc`=0x0001, `start` pulse, `mem_ack` with 0 waits, `mem_data`=0xA5C3:
  - `mem_rd` is high for 1 cycle with `mem_addr`=0x0001.
  - `ir`=0xA5C3 with `ir_valid` in the next cycle, alongside `pcwr`=1, `pc_src`=01, `alu_inc`=1.
  - `busy` falls 3 cycles after `start`.
- 3 wait cycles, then `mem_ack`: FETCH lasts 4 cycles, `ir_valid` appears 5 cycles after `start`, and no `bus_err`.
- `irq`=1, `irq_en`=1, `start`:
  - VECTOR cycle with `pcwr`=1, `pc_src`=10, `irq_ack`=1.
  - The fetch then reads `mem_addr`=0x0280 (with `pc` modelled as updated).
- `irq`=1, `irq_en`=0: normal fetch with no `irq_ack`.
- `TIMEOUT`=4 and `mem_ack` never asserted:
  - `mem_rd` is high for 4 cycles, then `bus_err` pulses once.
  - `ir` keeps its prior value and `pcwr` stays 0 throughout.
- `reset` asserted between clock edges during FETCH:
  - `mem_rd`, `busy` and `ir` go to 0 immediately.
  - A later `mem_ack` is ignored.
  - After `reset` is released, a `start` fetch completes normally.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Purpose: instruction-fetch sequencer; reads the instruction at pc over a rd/ack port, latches ir, and steps or vectors the PC.
// Latency: 2 cycles start-to-ir_valid (plus 1 per memory wait cycle, plus 1 for an interrupt vector cycle).
// Backpressure: start is only sampled in IDLE; a memory read that stalls for TIMEOUT cycles is abandoned with a bus_err pulse.
//
// Ports:
//   clock, reset            - system clock, asynchronous active-high reset
//   start                   - fetch request from the control unit (IDLE only)
//   pc                      - current PC register value
//   irq, irq_en             - level interrupt request and its enable
//   mem_rd/mem_addr         - memory read request and address (address is 0 when not reading)
//   mem_ack/mem_data        - memory read data valid and data
//   ir, ir_valid            - instruction register and its one-cycle "new" pulse
//   pcwr, pc_src, alu_inc   - PC register write controls (01 = pc+1 from ALU, 10 = vector 0x0280)
//   irq_ack, bus_err, busy  - interrupt acknowledge, fetch-timeout pulse, not-idle status
module fetch_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] pc,
    input  logic        irq,
    input  logic        irq_en,
    input  logic        mem_ack,
    input  logic [15:0] mem_data,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    output logic [15:0] ir,
    output logic        ir_valid,
    output logic        pcwr,
    output logic [1:0]  pc_src,
    output logic        alu_inc,
    output logic        irq_ack,
    output logic        bus_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_VECTOR = 2'd1,
        S_FETCH  = 2'd2,
        S_INC    = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_ALU  = 2'b01;
    localparam logic [1:0] SRC_VEC  = 2'b10;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  cnt_inc;
    logic [15:0] ir_q, ir_d;
    logic        bus_err_q, bus_err_d;
    logic        mem_rd_q, mem_rd_d;
    logic        pcwr_q, pcwr_d;
    logic [1:0]  pc_src_q, pc_src_d;
    logic        alu_inc_q, alu_inc_d;
    logic        ir_valid_q, ir_valid_d;
    logic        irq_ack_q, irq_ack_d;
    logic        busy_q, busy_d;

    assign cnt_inc = cnt_q + 8'd1;

    // Next-state logic. cnt_q holds the number of FETCH cycles already
    // completed, so cnt_inc counts the cycle ending at this edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ir_d      = ir_q;
        bus_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                if (start) begin
                    state_d = (irq && irq_en) ? S_VECTOR : S_FETCH;
                end
            end
            S_VECTOR: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                cnt_d = cnt_inc;
                // An ack on the same edge as the timeout still completes the fetch.
                if (mem_ack) begin
                    ir_d    = mem_data;
                    state_d = S_INC;
                end else if (cnt_inc == TIMEOUT_C) begin
                    bus_err_d = 1'b1;
                    cnt_d     = 8'd0;
                    state_d   = S_IDLE;
                end
            end
            S_INC: begin
                cnt_d   = 8'd0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so the PC
    // register sees stable pcwr/pc_src across the whole high phase.
    always_comb begin
        mem_rd_d   = (state_d == S_FETCH);
        pcwr_d     = (state_d == S_VECTOR) || (state_d == S_INC);
        alu_inc_d  = (state_d == S_INC);
        ir_valid_d = (state_d == S_INC);
        irq_ack_d  = (state_d == S_VECTOR);
        busy_d     = (state_d != S_IDLE);
        case (state_d)
            S_VECTOR: pc_src_d = SRC_VEC;
            S_INC:    pc_src_d = SRC_ALU;
            default:  pc_src_d = SRC_NONE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            ir_q       <= 16'h0000;
            bus_err_q  <= 1'b0;
            mem_rd_q   <= 1'b0;
            pcwr_q     <= 1'b0;
            pc_src_q   <= SRC_NONE;
            alu_inc_q  <= 1'b0;
            ir_valid_q <= 1'b0;
            irq_ack_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ir_q       <= ir_d;
            bus_err_q  <= bus_err_d;
            mem_rd_q   <= mem_rd_d;
            pcwr_q     <= pcwr_d;
            pc_src_q   <= pc_src_d;
            alu_inc_q  <= alu_inc_d;
            ir_valid_q <= ir_valid_d;
            irq_ack_q  <= irq_ack_d;
            busy_q     <= busy_d;
        end
    end

    assign mem_rd   = mem_rd_q;
    // Address follows pc live while reading so a vector load lands in the same fetch.
    assign mem_addr = mem_rd_q ? pc : 16'h0000;
    assign ir       = ir_q;
    assign ir_valid = ir_valid_q;
    assign pcwr     = pcwr_q;
    assign pc_src   = pc_src_q;
    assign alu_inc  = alu_inc_q;
    assign irq_ack  = irq_ack_q;
    assign bus_err  = bus_err_q;
    assign busy     = busy_q;

endmodule
